// File: rtl/musk_bus_pkg.sv
// -----------------------------------------------------------------------------
// musk_bus_pkg
//   Shared definitions for the Muskbus line protocol: line geometry, request
//   opcodes, the request/response tag layout and the responder state encoding.
// -----------------------------------------------------------------------------
package musk_bus_pkg;

    localparam int LINE_BYTES = 64;
    localparam int LINE_BEATS = 8;

    localparam logic [3:0] OP_WRITE = 4'h0;
    localparam logic [3:0] OP_READ  = 4'h1;

    // Tag carried on reqtag and echoed on resptag.
    typedef struct packed {
        logic [3:0]  op;
        logic [11:0] id;
    } bus_tag_t;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        LAT,
        RESP
    } resp_state_t;

endpackage

// File: rtl/musk_mem_array.sv
// -----------------------------------------------------------------------------
// musk_mem_array
//   Single-port backing store of MEM_WORDS 64-bit words. One word is read
//   combinationally; a whole line of LINE_BEATS words is written in one edge.
//   Contents are never reset.
//
// Ports:
//   clk      in   rising-edge clock
//   we       in   commit wr_line at wr_base..wr_base+7 (indices wrap)
//   wr_base  in   word index of the first word of the line
//   wr_line  in   line data, word 0 in [0]
//   rd_addr  in   word index to read
//   rd_data  out  combinational read data
// -----------------------------------------------------------------------------
module musk_mem_array
    import musk_bus_pkg::*;
#(
    parameter int MEM_WORDS = 65536,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic                             clk,
    input  logic                             we,
    input  logic [AW-1:0]                    wr_base,
    input  logic [LINE_BEATS-1:0][63:0]      wr_line,
    input  logic [AW-1:0]                    rd_addr,
    output logic [63:0]                      rd_data
);

    logic [63:0] mem [MEM_WORDS];

    // Index arithmetic is AW bits wide, so a line straddling the top of the
    // array wraps to index 0 with no special handling.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LINE_BEATS; i++) begin
                mem[wr_base + AW'(i)] <= wr_line[i];
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/muskbus_mem_responder.sv
// -----------------------------------------------------------------------------
// muskbus_mem_responder
//   Memory-side target of the Muskbus line protocol. Accepts an address beat,
//   then either collects 8 write beats and commits the line, or waits LATENCY
//   cycles and streams 8 read beats tagged with the request tag.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   reqcyc   in   request / write-data beat valid
//   reqack   out  one-cycle acceptance pulse (registered)
//   req      in   byte address (address beat) or write data (data beats)
//   reqtag   in   {op[3:0], id[11:0]}
//   respcyc  out  read response beat valid
//   respack  in   initiator consumed the current response beat
//   resp     out  read data word
//   resptag  out  tag captured from the read request
// -----------------------------------------------------------------------------
module muskbus_mem_responder
    import musk_bus_pkg::*;
#(
    parameter int MEM_WORDS = 65536,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reqcyc,
    output logic        reqack,
    input  logic [63:0] req,
    input  logic [15:0] reqtag,
    output logic        respcyc,
    input  logic        respack,
    output logic [63:0] resp,
    output logic [15:0] resptag
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam int          LCW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [2:0]  LAST_BEAT = 3'(LINE_BEATS - 1);

    resp_state_t                     state;
    logic [2:0]                      beat;
    logic [LCW-1:0]                  lat_cnt;
    logic [AW-1:0]                   line_idx;
    bus_tag_t                        tag_q;
    logic [LINE_BEATS-1:0][63:0]     line_buf;

    bus_tag_t                        req_tag;
    logic [AW-1:0]                   req_line_idx;
    logic                            mem_we;
    logic [LINE_BEATS-1:0][63:0]     wr_line;
    logic [2:0]                      rd_beat;
    logic [AW-1:0]                   rd_addr;
    logic [63:0]                     rd_data;

    assign req_tag = reqtag;

    // Word index of the line base; upper address bits beyond the array drop
    // out in the truncation, giving modulo wrap.
    assign req_line_idx = AW'((req & ~64'(LINE_BYTES - 1)) >> 3);

    // The last write beat goes straight from req into the commit so the line
    // lands in the array on the same edge that captures it.
    always_comb begin
        wr_line                 = line_buf;
        wr_line[LINE_BEATS-1]   = req;
    end

    assign mem_we = (state == WDATA) && reqcyc && (beat == LAST_BEAT);

    // Address of the word that will be loaded into resp on this edge: word 0
    // when leaving LAT, the following word while streaming.
    assign rd_beat = (state == RESP) ? beat + 3'd1 : 3'd0;
    assign rd_addr = line_idx + AW'(rd_beat);

    musk_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_base (line_idx),
        .wr_line (wr_line),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            reqack   <= 1'b0;
            respcyc  <= 1'b0;
            resp     <= '0;
            resptag  <= '0;
            beat     <= '0;
            lat_cnt  <= '0;
            line_idx <= '0;
            tag_q    <= '0;
            line_buf <= '0;
        end else begin
            reqack <= 1'b0;
            case (state)
                IDLE: begin
                    // While reqack is high the initiator may still be holding
                    // the beat just accepted, so it is not taken again.
                    if (reqcyc && !reqack) begin
                        reqack   <= 1'b1;
                        line_idx <= req_line_idx;
                        tag_q    <= req_tag;
                        beat     <= '0;
                        if (req_tag.op == OP_READ) begin
                            state   <= LAT;
                            lat_cnt <= LCW'(LATENCY - 1);
                        end else if (req_tag.op == OP_WRITE) begin
                            state <= WDATA;
                        end
                    end
                end

                WDATA: begin
                    if (reqcyc) begin
                        reqack         <= 1'b1;
                        line_buf[beat] <= req;
                        beat           <= beat + 3'd1;
                        if (beat == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end

                LAT: begin
                    if (lat_cnt == '0) begin
                        state   <= RESP;
                        beat    <= '0;
                        respcyc <= 1'b1;
                        resp    <= rd_data;
                        resptag <= tag_q;
                    end else begin
                        lat_cnt <= lat_cnt - LCW'(1);
                    end
                end

                RESP: begin
                    if (respack) begin
                        if (beat == LAST_BEAT) begin
                            respcyc <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            beat <= beat + 3'd1;
                            resp <= rd_data;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muskbus_mem_responder.sv
module tb_muskbus_mem_responder;
    import musk_bus_pkg::*;

    localparam int MEM_WORDS = 65536;
    localparam int LATENCY   = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reqcyc;
    logic        reqack;
    logic [63:0] req;
    logic [15:0] reqtag;
    logic        respcyc;
    logic        respack;
    logic [63:0] resp;
    logic [15:0] resptag;

    muskbus_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .reqcyc  (reqcyc),
        .reqack  (reqack),
        .req     (req),
        .reqtag  (reqtag),
        .respcyc (respcyc),
        .respack (respack),
        .resp    (resp),
        .resptag (resptag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] data;
        logic [15:0] tag;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [int];
    logic [63:0] wdata [8];
    logic [63:0] got_d [8];
    logic [15:0] got_t [8];

    function automatic int widx(logic [63:0] a, int b);
        logic [63:0] w;
        w = (((a & ~64'd63) >> 3) + 64'(b)) % 64'(MEM_WORDS);
        return int'(w);
    endfunction

    function automatic logic [63:0] mread(int i);
        if (model.exists(i)) return model[i];
        return 64'd0;
    endfunction

    task automatic model_write(input logic [63:0] a);
        for (int b = 0; b < 8; b++) model[widx(a, b)] = wdata[b];
    endtask

    task automatic push_read(input logic [63:0] a, input logic [15:0] t);
        exp_t e;
        for (int b = 0; b < 8; b++) begin
            e.data = mread(widx(a, b));
            e.tag  = t;
            sb.push_back(e);
        end
    endtask

    // Drives an address beat from a negedge and waits for reqack; returns at
    // the negedge where reqack is seen, with reqcyc dropped.
    task automatic send_addr(input logic [63:0] a, input logic [15:0] t,
                             output bit ok, output int waited);
        reqcyc = 1'b1; req = a; reqtag = t; ok = 1'b0; waited = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            waited++;
            if (reqack) begin ok = 1'b1; break; end
        end
        reqcyc = 1'b0;
    endtask

    // Streams n data beats from wdata, with a bubble cycle before each beat
    // whose bit is set in bub.
    task automatic send_data(input int n, input logic [7:0] bub,
                             output int acks, output int bub_acks);
        acks = 0; bub_acks = 0;
        for (int i = 0; i < n; i++) begin
            if (bub[i]) begin
                reqcyc = 1'b0;
                @(negedge clk);
                if (reqack) bub_acks++;
            end
            reqcyc = 1'b1; req = wdata[i];
            @(negedge clk);
            if (reqack) acks++;
        end
        reqcyc = 1'b0;
    endtask

    // Collects a read burst starting at the reqack negedge. lat counts
    // cycles from the reqack cycle to the first respcyc.
    task automatic collect(input int stall_beat, input int stall_cyc,
                           output int lat, output int beats, output int unstable,
                           output int held_acks, output bit tail_ok);
        lat = 0; beats = 0; unstable = 0; held_acks = 0;
        while (!respcyc && lat < 100) begin
            @(negedge clk);
            lat++;
            if (reqack) held_acks++;
        end
        for (int b = 0; b < 8; b++) begin
            if (!respcyc) break;
            got_d[b] = resp; got_t[b] = resptag; beats++;
            if (b == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    respack = 1'b0;
                    @(negedge clk);
                    if (reqack) held_acks++;
                    if (!respcyc || resp !== got_d[b] || resptag !== got_t[b]) unstable++;
                end
            end
            respack = 1'b1;
            @(negedge clk);
            if (reqack) held_acks++;
        end
        respack = 1'b0;
        tail_ok = !respcyc;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; reqcyc = 1'b0; req = '0; reqtag = '0; respack = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({reqack, respcyc, resp, resptag} !== 82'd0) begin
            bad++;
            $display("FAIL reset_outputs: got ack=%b cyc=%b resp=%h tag=%h want all 0",
                     reqack, respcyc, resp, resptag);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_unwritten;
        bit ok, tail; int w, lat, beats, uns, ha; exp_t e;
        send_addr(64'h1000, 16'h1005, ok, w);
        total++; if (!ok) begin bad++; $display("FAIL rd0_ack: got none want reqack"); end
        push_read(64'h1000, 16'h1005);
        collect(-1, 0, lat, beats, uns, ha, tail);
        total++; if (lat !== LATENCY) begin bad++; $display("FAIL rd0_latency: got %0d want %0d", lat, LATENCY); end
        total++; if (beats !== 8) begin bad++; $display("FAIL rd0_beats: got %0d want 8", beats); end
        total++; if (!tail) begin bad++; $display("FAIL rd0_tail: got respcyc=1 want 0"); end
        for (int b = 0; b < beats; b++) begin
            e = sb.pop_front();
            total++;
            if (got_d[b] !== e.data || got_t[b] !== e.tag) begin
                bad++;
                $display("FAIL rd0_beat%0d: got %h/%h want %h/%h", b, got_d[b], got_t[b], e.data, e.tag);
            end
        end
        sb.delete();
    endtask

    task automatic test_write_read;
        bit ok, tail; int w, acks, backs, lat, beats, uns, ha; exp_t e;
        for (int i = 0; i < 8; i++) wdata[i] = 64'h11 * 64'(i + 1);
        send_addr(64'h2040, {OP_WRITE, 12'h002}, ok, w);
        total++; if (!ok) begin bad++; $display("FAIL wr_addr_ack: got none want reqack"); end
        send_data(8, 8'h00, acks, backs);
        model_write(64'h2040);
        total++; if (acks !== 8) begin bad++; $display("FAIL wr_data_acks: got %0d want 8", acks); end
        send_addr(64'h2040, 16'h1001, ok, w);
        total++; if (!ok) begin bad++; $display("FAIL raw_ack: got none want reqack"); end
        push_read(64'h2040, 16'h1001);
        collect(-1, 0, lat, beats, uns, ha, tail);
        total++; if (beats !== 8) begin bad++; $display("FAIL raw_beats: got %0d want 8", beats); end
        for (int b = 0; b < beats; b++) begin
            e = sb.pop_front();
            total++;
            if (got_d[b] !== e.data || got_t[b] !== e.tag) begin
                bad++;
                $display("FAIL raw_beat%0d: got %h/%h want %h/%h", b, got_d[b], got_t[b], e.data, e.tag);
            end
        end
        sb.delete();
    endtask

    task automatic test_dropped_op;
        bit ok; int w;
        send_addr(64'h1000, 16'h7123, ok, w);
        total++; if (!ok) begin bad++; $display("FAIL drop_ack: got none want reqack"); end
        reqcyc = 1'b1;
        @(negedge clk);
        total++; if (reqack !== 1'b0) begin bad++; $display("FAIL idle_double_ack: got %b want 0", reqack); end
        reqcyc = 1'b0;
        repeat (LATENCY + 2) @(negedge clk);
        total++; if (respcyc !== 1'b0) begin bad++; $display("FAIL drop_no_resp: got %b want 0", respcyc); end
    endtask

    task automatic test_respack_stall;
        bit ok, tail; int w, lat, beats, uns, ha; exp_t e;
        send_addr(64'h2040, 16'h1077, ok, w);
        push_read(64'h2040, 16'h1077);
        collect(2, 3, lat, beats, uns, ha, tail);
        total++; if (uns !== 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", uns); end
        total++; if (beats !== 8) begin bad++; $display("FAIL stall_beats: got %0d want 8", beats); end
        for (int b = 0; b < beats; b++) begin
            e = sb.pop_front();
            total++;
            if (got_d[b] !== e.data || got_t[b] !== e.tag) begin
                bad++;
                $display("FAIL stall_beat%0d: got %h/%h want %h/%h", b, got_d[b], got_t[b], e.data, e.tag);
            end
        end
        sb.delete();
        @(negedge clk);
        total++; if (respcyc !== 1'b0 || !tail) begin bad++; $display("FAIL stall_extra_beat: got respcyc=%b want 0", respcyc); end
    endtask

    task automatic test_write_bubbles;
        bit ok, tail; int w, acks, backs, lat, beats, uns, ha; exp_t e;
        for (int i = 0; i < 8; i++) wdata[i] = {$urandom(), $urandom()};
        send_addr(64'h5000, {OP_WRITE, 12'h050}, ok, w);
        send_data(8, 8'b0100_1000, acks, backs);
        model_write(64'h5000);
        total++; if (acks !== 8) begin bad++; $display("FAIL bub_acks: got %0d want 8", acks); end
        total++; if (backs !== 0) begin bad++; $display("FAIL bub_bubble_ack: got %0d want 0", backs); end
        send_addr(64'h5000, 16'h1050, ok, w);
        push_read(64'h5000, 16'h1050);
        collect(-1, 0, lat, beats, uns, ha, tail);
        total++; if (beats !== 8) begin bad++; $display("FAIL bub_rd_beats: got %0d want 8", beats); end
        for (int b = 0; b < beats; b++) begin
            e = sb.pop_front();
            total++;
            if (got_d[b] !== e.data || got_t[b] !== e.tag) begin
                bad++;
                $display("FAIL bub_beat%0d: got %h/%h want %h/%h", b, got_d[b], got_t[b], e.data, e.tag);
            end
        end
        sb.delete();
    endtask

    task automatic test_reset_midburst;
        bit ok, tail; int w, acks, backs, lat, beats, uns, ha, n; exp_t e;
        for (int i = 0; i < 8; i++) wdata[i] = 64'hAAAA_AAAA_AAAA_AAAA;
        send_addr(64'h3000, {OP_WRITE, 12'h030}, ok, w);
        send_data(8, 8'h00, acks, backs);
        model_write(64'h3000);
        for (int i = 0; i < 8; i++) wdata[i] = 64'h5555_0000_0000_0000 | 64'(i);
        send_addr(64'h3000, {OP_WRITE, 12'h031}, ok, w);
        send_data(5, 8'h00, acks, backs);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_addr(64'h3000, 16'h1030, ok, w);
        total++; if (!ok) begin bad++; $display("FAIL rst_wr_ack: got none want reqack"); end
        push_read(64'h3000, 16'h1030);
        collect(-1, 0, lat, beats, uns, ha, tail);
        total++; if (beats !== 8) begin bad++; $display("FAIL rst_wr_beats: got %0d want 8", beats); end
        for (int b = 0; b < beats; b++) begin
            e = sb.pop_front();
            total++;
            if (got_d[b] !== e.data || got_t[b] !== e.tag) begin
                bad++;
                $display("FAIL rst_wr_beat%0d: got %h/%h want %h/%h", b, got_d[b], got_t[b], e.data, e.tag);
            end
        end
        sb.delete();
        // Abort a read in RESP; no response is expected for it.
        send_addr(64'h3000, 16'h1033, ok, w);
        n = 0;
        while (!respcyc && n < 100) begin @(negedge clk); n++; end
        total++; if (!respcyc) begin bad++; $display("FAIL rst_rd_start: got respcyc=0 want 1"); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (respcyc !== 1'b0 || resp !== 64'd0) begin bad++; $display("FAIL rst_rd_abort: got respcyc=%b resp=%h want 0", respcyc, resp); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wrap_and_hold;
        bit ok, tail; int w, acks, backs, lat, beats, uns, ha; exp_t e;
        logic [63:0] wa;
        wa = 64'(MEM_WORDS) * 64'd8 + 64'h40;
        for (int i = 0; i < 8; i++) wdata[i] = 64'h5A5A_5A5A_5A5A_5A00 | 64'(i);
        send_addr(wa, {OP_WRITE, 12'h0A0}, ok, w);
        send_data(8, 8'h00, acks, backs);
        model_write(wa);
        send_addr(64'h40, 16'h1040, ok, w);
        push_read(64'h40, 16'h1040);
        // Next request held across the whole burst.
        reqcyc = 1'b1; req = 64'h2040; reqtag = 16'h1041;
        collect(-1, 0, lat, beats, uns, ha, tail);
        total++; if (ha !== 0) begin bad++; $display("FAIL hold_ack_in_resp: got %0d acks want 0", ha); end
        total++; if (beats !== 8) begin bad++; $display("FAIL wrap_beats: got %0d want 8", beats); end
        for (int b = 0; b < beats; b++) begin
            e = sb.pop_front();
            total++;
            if (got_d[b] !== e.data || got_t[b] !== e.tag) begin
                bad++;
                $display("FAIL wrap_beat%0d: got %h/%h want %h/%h", b, got_d[b], got_t[b], e.data, e.tag);
            end
        end
        sb.delete();
        send_addr(64'h2040, 16'h1041, ok, w);
        total++; if (!ok || w !== 1) begin bad++; $display("FAIL b2b_accept: got ok=%b wait=%0d want ok=1 wait=1", ok, w); end
        push_read(64'h2040, 16'h1041);
        collect(-1, 0, lat, beats, uns, ha, tail);
        total++; if (beats !== 8) begin bad++; $display("FAIL b2b_beats: got %0d want 8", beats); end
        for (int b = 0; b < beats; b++) begin
            e = sb.pop_front();
            total++;
            if (got_d[b] !== e.data || got_t[b] !== e.tag) begin
                bad++;
                $display("FAIL b2b_beat%0d: got %h/%h want %h/%h", b, got_d[b], got_t[b], e.data, e.tag);
            end
        end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_read_unwritten();
        test_write_read();
        test_dropped_op();
        test_respack_stall();
        test_write_bubbles();
        test_reset_midburst();
        test_wrap_and_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muskbus_mem_responder.md
Name: muskbus_mem_responder

Overview:
- Memory-side responder for the Muskbus line protocol; it serves the line reads and line writes that the core's I-cache and D-cache issue.
- Accepts a request address beat, then either collects 8 write data beats or waits a fixed latency and returns 8 read beats tagged with the request tag.
- Used as the simulation memory end of the bus, and as the bus target for cache and core benches.

Parameters:
MEM_WORDS, 65536, depth of backing store in 64-bit words; power of two.
LATENCY, 4, cycles from read address acceptance to first response beat; legal range is 1 or more.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
reqcyc  input  1  initiator has a valid request or write-data beat on req/reqtag.
reqack  output  1  one-cycle pulse; acknowledges acceptance of one request or data beat.
req  input  64  byte address on the address beat; write data on data beats.
reqtag  input  16  [15:12] op (OP_READ=4'h1, OP_WRITE=4'h0), [11:0] id.
respcyc  output  1  read response beat valid.
respack  input  1  initiator consumed the current response beat.
resp  output  64  read data word.
resptag  output  16  tag captured from the read request.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, reqack=0, respcyc=0, resp=0, resptag=0, beat and latency counters=0, line buffer discarded. The memory array is not reset; its contents survive reset.
- Line address: line = req & ~63; word index = ((line>>3)+beat) mod MEM_WORDS. Addresses beyond the array wrap modulo; no error is raised.
- All outputs are registered.
- States:
  - IDLE:
    - reqcyc=1 at an edge: capture req, reqtag; reqack=1 for the next cycle only.
    - op READ -> LAT with lat_cnt=LATENCY-1.
    - op WRITE -> WDATA with beat=0.
    - Any other op: acked and dropped; stays IDLE.
  - WDATA:
    - Each edge with reqcyc=1 stores req into line buffer[beat], pulses reqack next cycle, and increments beat.
    - Cycles with reqcyc=0 are bubbles: beat holds, no ack.
    - After beat 7 is captured, the 8 words are committed to the array in the same edge -> IDLE.
    - Writes produce no response.
  - LAT:
    - lat_cnt decrements each cycle; at 0 -> RESP with beat=0.
    - The cycle after entering RESP: respcyc=1, resp=word 0, resptag=captured tag.
    - Read latency from the reqack cycle to the first respcyc is LATENCY cycles.
  - RESP:
    - respcyc stays high. resp/resptag stay stable while respack=0.
    - respack=1 at an edge advances to the next word.
    - After word 7 is acknowledged, respcyc=0 the next cycle -> IDLE.
    - Back-to-back reads are allowed: a reqcyc present on the cycle IDLE is re-entered is accepted on that edge.
- Requests arriving in a non-IDLE state are not acknowledged. The initiator holds reqcyc/req/reqtag until reqack.
- Read-after-write to the same line returns the newly committed data, because the commit completes before IDLE.
- Reset mid-burst: a partial write is discarded, so the array is unmodified. A read in progress is aborted and respcyc drops immediately.
- reqack never asserts in two consecutive cycles in IDLE. It can assert on consecutive cycles in WDATA.

Decomposition:
- Package musk_bus_pkg holds:
  - constants LINE_BYTES=64, LINE_BEATS=8, OP_READ, OP_WRITE;
  - typedef bus_tag_t (16-bit packed struct: op[3:0], id[11:0]);
  - enum resp_state_t {IDLE, WDATA, LAT, RESP}.
- One sub-module, musk_mem_array:
  - single-port 64-bit x MEM_WORDS array;
  - combinational read of one word;
  - 8-word line write with enable.
- The FSM, counters and line buffer stay in the top.

Test Plan:
1. Reset, then a read of 0x1000 (tag 0x1005) on unwritten memory -> reqack one cycle; respcyc after 4 cycles; 8 beats of resp=0 with resptag=0x1005.
2. Write to 0x2040 with data 0x11..0x88, one beat per cycle, then a read of 0x2040 (tag 0x1001) -> 8 reqacks on data beats; read returns 0x11..0x88 in order.
3. Read with respack low for 3 cycles on beat 2 -> resp holds word 2 stable; 8 beats total; no extra beats; back to IDLE.
4. Write burst with reqcyc bubbles at beats 3 and 6 -> beat count holds during bubbles; line committed only after the 8th captured beat; readback matches.
5. reset_n pulled low after 5 write beats to 0x3000 (pre-filled with 0xAA) -> readback after reset is all 0xAA. A second reset during read RESP -> respcyc=0 immediately.
6. Address 64*MEM_WORDS/8 + 0x40 (wrap) written with 0x5A pattern -> reading 0x40 returns 0x5A pattern. A reqcyc held during RESP is not acked until IDLE.
